// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter of GPU data-memory channels onto one single-port SRAM
// One access in flight at a time; every output is registered.
module data_mem_arbiter #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int MEM_LATENCY  = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CHANNELS-1:0]                  ch_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   ch_read_address,
  output logic [NUM_CHANNELS-1:0]                  ch_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   ch_read_data,
  input  logic [NUM_CHANNELS-1:0]                  ch_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   ch_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   ch_write_data,
  output logic [NUM_CHANNELS-1:0]                  ch_write_ready,
  output logic                                     sram_en,
  output logic                                     sram_we,
  output logic [ADDR_BITS-1:0]                     sram_addr,
  output logic [DATA_BITS-1:0]                     sram_wdata,
  input  logic [DATA_BITS-1:0]                     sram_rdata
);

  localparam int CH_BITS  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_BITS = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                   state;
  logic [CH_BITS-1:0]       g;
  logic [CH_BITS-1:0]       rr_ptr;
  logic [CH_BITS-1:0]       mask_ch;
  logic                     mask_valid;
  logic                     op_we;
  logic [CNT_BITS-1:0]      cnt;

  logic [NUM_CHANNELS-1:0]  pending;
  logic [CH_BITS-1:0]       pick;
  logic [CH_BITS-1:0]       idx;
  logic                     found;

  // The just-served channel is hidden for one cycle because its requester drops valid one edge late.
  always_comb begin
    pending = '0;
    found   = 1'b0;
    pick    = rr_ptr;
    idx     = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      pending[c] = (ch_read_valid[c] | ch_write_valid[c]) &
                   ~(mask_valid & (mask_ch == CH_BITS'(c)));
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = CH_BITS'((int'(rr_ptr) + i) % NUM_CHANNELS);
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      g              <= '0;
      rr_ptr         <= '0;
      mask_ch        <= '0;
      mask_valid     <= 1'b0;
      op_we          <= 1'b0;
      cnt            <= '0;
      sram_en        <= 1'b0;
      sram_we        <= 1'b0;
      sram_addr      <= '0;
      sram_wdata     <= '0;
      ch_read_ready  <= '0;
      ch_write_ready <= '0;
      ch_read_data   <= '0;
    end else begin
      mask_valid     <= 1'b0;
      sram_en        <= 1'b0;
      sram_we        <= 1'b0;
      ch_read_ready  <= '0;
      ch_write_ready <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            // Read wins when both valids are up; the write is picked up on a later grant.
            g          <= pick;
            op_we      <= ~ch_read_valid[pick];
            sram_en    <= 1'b1;
            sram_we    <= ~ch_read_valid[pick];
            sram_addr  <= ch_read_valid[pick] ? ch_read_address[pick] : ch_write_address[pick];
            sram_wdata <= ch_write_data[pick];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_we) begin
            ch_write_ready[g] <= 1'b1;
            state             <= ACK;
          end else begin
            cnt   <= CNT_BITS'(MEM_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            ch_read_data[g]  <= sram_rdata;
            ch_read_ready[g] <= 1'b1;
            state            <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          rr_ptr     <= (g == CH_BITS'(NUM_CHANNELS - 1)) ? '0 : g + 1'b1;
          mask_valid <= 1'b1;
          mask_ch    <= g;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter at SRAM latencies 1, 2 and 4
module tb_data_mem_arbiter;

  localparam int NCH = 4;

  typedef struct {
    int         k;
    int         c;
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } sb_t;

  function automatic logic [7:0] init_val(int a);
    return 8'(a) ^ 8'h3C;
  endfunction

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NCH-1:0]      rv [3];
  logic [NCH-1:0]      wv [3];
  logic [NCH-1:0]      rr [3];
  logic [NCH-1:0]      wr [3];
  logic [NCH-1:0][7:0] ra [3];
  logic [NCH-1:0][7:0] wa [3];
  logic [NCH-1:0][7:0] wd [3];
  logic [NCH-1:0][7:0] rd [3];
  logic                en [3];
  logic                we [3];
  logic [7:0]          saddr [3];
  logic [7:0]          swd [3];
  logic [7:0]          srd [3];

  generate
    for (genvar k = 0; k < 3; k++) begin : g_inst
      localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
      logic [7:0] mem  [256];
      logic [7:0] pipe [L];

      data_mem_arbiter #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(NCH), .MEM_LATENCY(L)
      ) dut (
        .clk(clk), .reset(reset),
        .ch_read_valid(rv[k]), .ch_read_address(ra[k]),
        .ch_read_ready(rr[k]), .ch_read_data(rd[k]),
        .ch_write_valid(wv[k]), .ch_write_address(wa[k]), .ch_write_data(wd[k]),
        .ch_write_ready(wr[k]),
        .sram_en(en[k]), .sram_we(we[k]), .sram_addr(saddr[k]),
        .sram_wdata(swd[k]), .sram_rdata(srd[k])
      );

      initial for (int i = 0; i < 256; i++) mem[i] = init_val(i);

      // Read data appears only in the cycle exactly L after the strobe; zero otherwise.
      always @(posedge clk) begin
        if (en[k] && we[k]) mem[saddr[k]] <= swd[k];
        for (int j = L - 1; j > 0; j--) pipe[j] <= pipe[j-1];
        pipe[0] <= (en[k] && !we[k]) ? mem[saddr[k]] : 8'h00;
      end
      assign srd[k] = pipe[L-1];
    end
  endgenerate

  sb_t        sb [$];
  logic [7:0] ref_mem [3][256];
  int         rem_r [3][NCH];
  int         rem_w [3][NCH];
  int         drop_r [3][NCH];
  int         drop_w [3][NCH];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(int k, int c, bit is_rd, logic [7:0] a, logic [7:0] d, int ecyc);
    sb_t e;
    e.k = k; e.c = c; e.rd = is_rd; e.cyc = ecyc;
    if (is_rd) begin
      ra[k][c] = a; rv[k][c] = 1'b1; rem_r[k][c]++;
      e.data = ref_mem[k][a];
    end else begin
      wa[k][c] = a; wd[k][c] = d; wv[k][c] = 1'b1; rem_w[k][c]++;
      e.data = d; ref_mem[k][a] = d;
    end
    sb.push_back(e);
  endtask

  // Requester model: valid is dropped two negedges after the ready pulse is seen.
  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < NCH; c++) begin
          if (drop_r[k][c] == cyc) begin rv[k][c] = 1'b0; drop_r[k][c] = -1; end
          if (drop_w[k][c] == cyc) begin wv[k][c] = 1'b0; drop_w[k][c] = -1; end
        end
      if (reset) begin
        for (int k = 0; k < 3; k++)
          for (int c = 0; c < NCH; c++) begin
            if (rr[k][c] || wr[k][c]) begin
              if (sb.size() == 0) begin
                chk($sformatf("spurious_ready_i%0d_ch%0d", k, c), 32'd1, 32'd0);
              end else begin
                e = sb.pop_front();
                chk("ready_inst", k, e.k);
                chk($sformatf("ready_ch_i%0d", k), c, e.c);
                chk($sformatf("ready_is_read_i%0d_ch%0d", k, c), rr[k][c], e.rd);
                chk($sformatf("ready_cycle_i%0d_ch%0d", k, c), cyc, e.cyc);
                if (e.rd) chk($sformatf("read_data_i%0d_ch%0d", k, c), rd[k][c], e.data);
              end
              if (rr[k][c]) begin
                rem_r[k][c]--;
                if (rem_r[k][c] <= 0) begin rem_r[k][c] = 0; drop_r[k][c] = cyc + 2; end
              end
              if (wr[k][c]) begin
                rem_w[k][c]--;
                if (rem_w[k][c] <= 0) begin rem_w[k][c] = 0; drop_w[k][c] = cyc + 2; end
              end
            end
          end
      end
    end
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(int k, string where);
    chk($sformatf("%s_en_i%0d", where, k), en[k], 0);
    chk($sformatf("%s_we_i%0d", where, k), we[k], 0);
    chk($sformatf("%s_addr_i%0d", where, k), saddr[k], 0);
    chk($sformatf("%s_wdata_i%0d", where, k), swd[k], 0);
    chk($sformatf("%s_rready_i%0d", where, k), rr[k], 0);
    chk($sformatf("%s_wready_i%0d", where, k), wr[k], 0);
    chk($sformatf("%s_rdata_i%0d", where, k), rd[k], 0);
  endtask

  task automatic run_basic(int k);
    int L;
    int s;
    L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    @(negedge clk); s = cyc;
    req(k, 2, 0, 8'h10, 8'hA5, s + 2);
    @(negedge clk);
    chk($sformatf("issue_en_i%0d", k), en[k], 1);
    chk($sformatf("issue_we_i%0d", k), we[k], 1);
    chk($sformatf("issue_addr_i%0d", k), saddr[k], 8'h10);
    chk($sformatf("issue_wdata_i%0d", k), swd[k], 8'hA5);
    @(negedge clk);
    chk($sformatf("en_one_cycle_i%0d", k), en[k], 0);
    drain(20);

    @(negedge clk); s = cyc;
    req(k, 1, 1, 8'h10, 8'h00, s + L + 2);
    drain(20);
    chk($sformatf("read_data_held_i%0d", k), rd[k][1], 8'hA5);

    @(negedge clk); s = cyc;
    req(k, 3, 0, 8'h30, 8'h77, s + 2);
    drain(20);

    @(negedge clk); s = cyc;
    for (int c = 0; c < NCH; c++)
      req(k, c, 1, 8'(32 + c), 8'h00, s + L + 2 + (L + 3) * c);
    drain(100);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("all_read_data_i%0d_ch%0d", k, c), rd[k][c], ref_mem[k][32 + c]);
  endtask

  initial begin
    int s;
    for (int k = 0; k < 3; k++) begin
      rv[k] = '0; wv[k] = '0; ra[k] = '0; wa[k] = '0; wd[k] = '0;
      for (int c = 0; c < NCH; c++) begin
        rem_r[k][c] = 0; rem_w[k][c] = 0; drop_r[k][c] = -1; drop_w[k][c] = -1;
      end
      for (int a = 0; a < 256; a++) ref_mem[k][a] = init_val(a);
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");
    reset = 1'b1;

    run_basic(1);

    // ch0 re-requests continuously against a constant ch3 requester.
    @(negedge clk); s = cyc;
    for (int i = 0; i < 3; i++) begin
      req(1, 0, 0, 8'h40, 8'h11, s + 2 + 6 * i);
      req(1, 3, 0, 8'h43, 8'h33, s + 5 + 6 * i);
    end
    drain(60);

    // Both valids on one channel: read first, write after the masked cycle.
    @(negedge clk); s = cyc;
    req(1, 2, 1, 8'h50, 8'h00, s + 4);
    req(1, 2, 0, 8'h50, 8'h5E, s + 8);
    drain(30);
    @(negedge clk); s = cyc;
    req(1, 2, 1, 8'h50, 8'h00, s + 4);
    drain(20);

    // Reset while a read on ch1 sits in WAIT, then let the held request reissue.
    @(negedge clk);
    rv[1][1] = 1'b1; ra[1][1] = 8'h10;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero(1, "midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    s = cyc;
    req(1, 1, 1, 8'h10, 8'h00, s + 4);
    drain(20);

    run_basic(0);
    run_basic(2);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
